// File: rtl/wiper_motor_sequencer.sv
// Windshield wiper motor sequencer.
// Arbitrates between the automatic and manual speed requests and runs the
// out-stroke / return-stroke / park-dwell cycle. Speed changes and stops take
// effect only at the park position. All outputs are Moore-decoded from
// registered state.
// Optional feature: define WIPER_WASH_EN to build the washer spray state and
// the forced low-speed wash wipes. When it is undefined, pump_on is tied low
// and wash_req is ignored.
module wiper_motor_sequencer #(
  parameter int LOW_STROKE_CYC  = 8,
  parameter int HIGH_STROKE_CYC = 4,
  parameter int PARK_DWELL_CYC  = 2,
  parameter int WASH_SPRAY_CYC  = 6,
  parameter int WASH_WIPES      = 3
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic [1:0] spd_req,
  input  logic       manual_en,
  input  logic [1:0] manual_spd,
  input  logic       wash_req,
  output logic       motor_on,
  output logic       motor_dir,
  output logic       motor_fast,
  output logic       parked,
  output logic       pump_on,
  output logic [2:0] state_dbg,
  output logic [7:0] sweep_cnt
);

  typedef enum logic [2:0] {
    ST_PARK  = 3'd0,
    ST_OUT   = 3'd1,
    ST_RET   = 3'd2,
    ST_DWELL = 3'd3,
    ST_SPRAY = 3'd4
  } state_e;

  // Down-counter load values: a phase of N cycles loads N-1 and ends at 0.
  localparam logic [7:0] LOW_LD   = 8'(LOW_STROKE_CYC - 1);
  localparam logic [7:0] HIGH_LD  = 8'(HIGH_STROKE_CYC - 1);
  localparam logic [7:0] DWELL_LD = 8'(PARK_DWELL_CYC - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       spd_lat_q, spd_lat_d;
  logic [7:0] sweep_q, sweep_d;

  logic [1:0] eff_spd;
  logic       eff_nz;
  logic       eff_hi;
  logic       wash_rise;
  logic       wipes_pend;

  // Manual lever wins when enabled; code 3 behaves as high, so bit 1 alone
  // marks a high-speed request.
  assign eff_spd = manual_en ? manual_spd : spd_req;
  assign eff_nz  = |eff_spd;
  assign eff_hi  = eff_spd[1];

  // Half-stroke length for a given latched speed.
  function automatic logic [7:0] stroke_ld(input logic hi);
    return hi ? HIGH_LD : LOW_LD;
  endfunction

`ifdef WIPER_WASH_EN
  localparam logic [7:0] SPRAY_LD  = 8'(WASH_SPRAY_CYC - 1);
  localparam logic [7:0] WIPES_LD  = 8'(WASH_WIPES);

  logic       wash_q;
  logic [7:0] wipes_q, wipes_d;

  // A wash request is the rising edge of the level input; it is only acted on
  // in PARK/DWELL, so edges seen in any other state are simply lost.
  assign wash_rise  = wash_req & ~wash_q;
  assign wipes_pend = |wipes_q;

  // Wash edge detector and count of forced wash wipes still to run.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      wash_q  <= 1'b0;
      wipes_q <= '0;
    end else begin
      wash_q  <= wash_req;
      wipes_q <= wipes_d;
    end
  end
`else
  logic wash_unused;

  assign wash_unused = wash_req;
  assign wash_rise   = 1'b0;
  assign wipes_pend  = 1'b0;
`endif

  // State, phase counter, latched sweep speed and completed-sweep counter.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_q   <= ST_PARK;
      cnt_q     <= '0;
      spd_lat_q <= 1'b0;
      sweep_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      spd_lat_q <= spd_lat_d;
      sweep_q   <= sweep_d;
    end
  end

  // Next-state logic: speed is only re-evaluated at the park position.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    spd_lat_d = spd_lat_q;
    sweep_d   = sweep_q;
`ifdef WIPER_WASH_EN
    wipes_d   = wipes_q;
`endif

    case (state_q)
      ST_PARK: begin
        if (wash_rise) begin
`ifdef WIPER_WASH_EN
          state_d = ST_SPRAY;
          cnt_d   = SPRAY_LD;
`endif
        end else if (eff_nz) begin
          state_d   = ST_OUT;
          spd_lat_d = eff_hi;
          cnt_d     = stroke_ld(eff_hi);
        end
      end

      ST_OUT: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_RET;
          cnt_d   = stroke_ld(spd_lat_q);
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_RET: begin
        if (cnt_q == 8'd0) begin
          sweep_d = sweep_q + 8'd1;
`ifdef WIPER_WASH_EN
          if (wipes_pend) begin
            wipes_d = wipes_q - 8'd1;
          end
`endif
          // High speed runs sweeps back-to-back; anything else parks briefly.
          if (spd_lat_q && eff_hi) begin
            state_d   = ST_OUT;
            spd_lat_d = 1'b1;
            cnt_d     = HIGH_LD;
          end else begin
            state_d = ST_DWELL;
            cnt_d   = DWELL_LD;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_DWELL: begin
        if (wash_rise) begin
`ifdef WIPER_WASH_EN
          state_d = ST_SPRAY;
          cnt_d   = SPRAY_LD;
`endif
        end else if (cnt_q == 8'd0) begin
          if (eff_nz || wipes_pend) begin
            // Pending wash wipes force low speed whatever is requested.
            state_d   = ST_OUT;
            spd_lat_d = wipes_pend ? 1'b0 : eff_hi;
            cnt_d     = stroke_ld(wipes_pend ? 1'b0 : eff_hi);
          end else begin
            state_d = ST_PARK;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

`ifdef WIPER_WASH_EN
      ST_SPRAY: begin
        if (cnt_q == 8'd0) begin
          wipes_d   = WIPES_LD;
          state_d   = ST_OUT;
          spd_lat_d = 1'b0;
          cnt_d     = LOW_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
`endif

      default: begin
        state_d = ST_PARK;
        cnt_d   = '0;
      end
    endcase
  end

  // Moore output decode.
  assign motor_on   = (state_q == ST_OUT) || (state_q == ST_RET);
  assign motor_dir  = (state_q == ST_OUT);
  assign motor_fast = motor_on && spd_lat_q;
  assign parked     = (state_q == ST_PARK) || (state_q == ST_DWELL);
  assign state_dbg  = state_q;
  assign sweep_cnt  = sweep_q;
`ifdef WIPER_WASH_EN
  assign pump_on    = (state_q == ST_SPRAY);
`else
  assign pump_on    = 1'b0;
`endif

endmodule

// File: tb/tb_wiper_motor_sequencer.sv
// Self-checking bench for wiper_motor_sequencer: a segment-queue model of the
// wiper (whole sweeps, dwells, sprays scheduled as frame lists) checked every
// cycle, plus directed scenarios with literal expectations and random stimulus.
module tb_wiper_motor_sequencer;

`ifdef WIPER_WASH_EN
  localparam bit WASH = 1'b1;
`else
  localparam bit WASH = 1'b0;
`endif
  localparam int WIPES_N = 3;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] spd_req = 2'd0;
  logic       manual_en = 1'b0;
  logic [1:0] manual_spd = 2'd0;
  logic       wash_req = 1'b0;
  logic       motor_on, motor_dir, motor_fast, parked, pump_on;
  logic [2:0] state_dbg;
  logic [7:0] sweep_cnt;

  wiper_motor_sequencer dut (
    .clk_2      (clk_2),
    .reset      (reset),
    .spd_req    (spd_req),
    .manual_en  (manual_en),
    .manual_spd (manual_spd),
    .wash_req   (wash_req),
    .motor_on   (motor_on),
    .motor_dir  (motor_dir),
    .motor_fast (motor_fast),
    .parked     (parked),
    .pump_on    (pump_on),
    .state_dbg  (state_dbg),
    .sweep_cnt  (sweep_cnt)
  );

  always #5 clk_2 = ~clk_2;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [2:0] st;
    logic       on;
    logic       dir;
    logic       fast;
    logic       prk;
    logic       pump;
  } frame_t;

  localparam int SEG_PARK = 0, SEG_SWEEP = 1, SEG_DWELL = 2, SEG_SPRAY = 3;

  frame_t q[$];
  frame_t exp_fr = '{st: 3'd0, on: 1'b0, dir: 1'b0, fast: 1'b0, prk: 1'b1, pump: 1'b0};
  int     exp_sweeps = 0;
  int     wipes = 0;
  int     last_seg = SEG_PARK;
  bit     last_fast = 1'b0;
  bit     w_prev = 1'b0;

  function automatic frame_t mk(input logic [2:0] st, input logic on, input logic dir,
                                input logic fast, input logic prk, input logic pump);
    frame_t f;
    f.st = st; f.on = on; f.dir = dir; f.fast = fast; f.prk = prk; f.pump = pump;
    return f;
  endfunction

  task automatic push_sweep(input bit fast);
    int n;
    n = fast ? 4 : 8;
    for (int i = 0; i < n; i++) q.push_back(mk(3'd1, 1'b1, 1'b1, fast, 1'b0, 1'b0));
    for (int i = 0; i < n; i++) q.push_back(mk(3'd2, 1'b1, 1'b0, fast, 1'b0, 1'b0));
    last_seg  = SEG_SWEEP;
    last_fast = fast;
  endtask

  task automatic push_dwell();
    for (int i = 0; i < 2; i++) q.push_back(mk(3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    last_seg = SEG_DWELL;
  endtask

  task automatic push_park();
    q.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    last_seg = SEG_PARK;
  endtask

  task automatic push_spray();
    for (int i = 0; i < 6; i++) q.push_back(mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    last_seg = SEG_SPRAY;
  endtask

  task automatic model_step();
    logic [1:0] eff;
    bit hi, nz, rise;
    logic [2:0] cur;
    eff  = manual_en ? manual_spd : spd_req;
    hi   = (eff >= 2'd2);
    nz   = (eff != 2'd0);
    rise = WASH && wash_req && !w_prev;
    w_prev = wash_req;
    cur  = exp_fr.st;
    if (rise && (cur == 3'd0 || cur == 3'd3)) begin
      q.delete();
      push_spray();
    end else if (q.size() == 0) begin
      case (last_seg)
        SEG_PARK: if (nz) push_sweep(hi); else push_park();
        SEG_SWEEP: begin
          exp_sweeps = (exp_sweeps + 1) % 256;
          if (wipes > 0) wipes--;
          if (last_fast && hi) push_sweep(1'b1); else push_dwell();
        end
        SEG_DWELL: begin
          if (wipes > 0) push_sweep(1'b0);
          else if (nz) push_sweep(hi);
          else push_park();
        end
        default: begin
          wipes = WIPES_N;
          push_sweep(1'b0);
        end
      endcase
    end
    exp_fr = q.pop_front();
  endtask

  always @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      q.delete();
      exp_fr     = mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      exp_sweeps = 0;
      wipes      = 0;
      last_seg   = SEG_PARK;
      last_fast  = 1'b0;
      w_prev     = 1'b0;
    end else begin
      model_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk_2) begin
    chk("state_dbg",  int'(state_dbg),  int'(exp_fr.st));
    chk("motor_on",   int'(motor_on),   int'(exp_fr.on));
    chk("motor_dir",  int'(motor_dir),  int'(exp_fr.dir));
    chk("motor_fast", int'(motor_fast), int'(exp_fr.fast));
    chk("parked",     int'(parked),     int'(exp_fr.prk));
    chk("pump_on",    int'(pump_on),    int'(exp_fr.pump));
    chk("sweep_cnt",  int'(sweep_cnt),  exp_sweeps);
  end

  // ---------------- directed + random stimulus ----------------
  task automatic wait_state(input int st, input int budget, input string nm);
    int k;
    k = 0;
    while (int'(state_dbg) != st && k < budget) begin
      @(negedge clk_2);
      k++;
    end
    chk(nm, int'(state_dbg), st);
  endtask

  task automatic step();
    @(negedge clk_2);
    #1;
  endtask

  initial begin
    int n, nd, m, k, base;
    bit fs;
    reset = 1'b1;
    repeat (2) @(negedge clk_2);
    chk("rst_state",  int'(state_dbg), 0);
    chk("rst_on",     int'(motor_on), 0);
    chk("rst_dir",    int'(motor_dir), 0);
    chk("rst_fast",   int'(motor_fast), 0);
    chk("rst_parked", int'(parked), 1);
    chk("rst_pump",   int'(pump_on), 0);
    chk("rst_sweep",  int'(sweep_cnt), 0);
    reset   = 1'b0;

    // Low speed: 16 motor cycles (8 out), 2 dwell, then sweep again.
    spd_req = 2'd1;
    @(negedge clk_2);
    n = 0; nd = 0;
    while (motor_on && n < 100) begin
      n++;
      if (motor_dir) nd++;
      @(negedge clk_2);
    end
    chk("low_on_cycles", n, 16);
    chk("low_out_cycles", nd, 8);
    chk("low_sweep_cnt", int'(sweep_cnt), 1);
    m = 0;
    while (parked && m < 100) begin
      m++;
      @(negedge clk_2);
    end
    chk("low_dwell_cycles", m, 2);
    chk("low_resweep", int'(state_dbg), 1);
    spd_req = 2'd0;
    wait_state(0, 100, "low_stop_park");
    chk("low_sweep_cnt2", int'(sweep_cnt), 2);

    // High speed: back-to-back 4+4 sweeps, then stop at OUT cycle 2.
    base = int'(sweep_cnt);
    spd_req = 2'd2;
    n = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk_2);
      if (motor_on && motor_fast) n++;
    end
    chk("high_b2b_on", n, 9);
    chk("high_b2b_dir", int'(motor_dir), 1);
    chk("high_sweep", int'(sweep_cnt), (base + 1) % 256);
    @(negedge clk_2);
    spd_req = 2'd0;
    @(negedge clk_2);
    n = 0;
    while (motor_on && n < 100) begin
      n++;
      @(negedge clk_2);
    end
    chk("high_stop_tail", n, 6);
    m = 0;
    while (parked && int'(state_dbg) == 3 && m < 100) begin
      m++;
      @(negedge clk_2);
    end
    chk("high_stop_dwell", m, 2);
    chk("high_stop_park", int'(state_dbg), 0);

    // Manual override to off holds PARK; releasing it starts a sweep.
    spd_req = 2'd2; manual_en = 1'b1; manual_spd = 2'd0;
    repeat (20) @(negedge clk_2);
    chk("ovr_park", int'(state_dbg), 0);
    manual_en = 1'b0;
    @(negedge clk_2);
    chk("ovr_release", int'(state_dbg), 1);
    spd_req = 2'd0;
    wait_state(0, 100, "ovr_stop_park");

`ifdef WIPER_WASH_EN
    // Wash: 6 pump cycles, three low sweeps, back to PARK.
    base = int'(sweep_cnt);
    wash_req = 1'b1;
    @(negedge clk_2);
    chk("wash_spray", int'(state_dbg), 4);
    wash_req = 1'b0;
    n = 0;
    while (pump_on && n < 50) begin
      n++;
      @(negedge clk_2);
    end
    chk("wash_pump_cycles", n, 6);
    fs = 1'b0; k = 0;
    while (int'(state_dbg) != 0 && k < 300) begin
      if (motor_fast) fs = 1'b1;
      @(negedge clk_2);
      k++;
    end
    chk("wash_end_park", int'(state_dbg), 0);
    chk("wash_low_only", int'(fs), 0);
    chk("wash_sweeps", int'(sweep_cnt), (base + 3) % 256);
`endif

    // Asynchronous reset in the middle of an out-stroke.
    spd_req = 2'd1;
    @(negedge clk_2);
    @(negedge clk_2);
    #2 reset = 1'b1;
    #1;
    chk("amid_state", int'(state_dbg), 0);
    chk("amid_on", int'(motor_on), 0);
    chk("amid_parked", int'(parked), 1);
    chk("amid_sweep", int'(sweep_cnt), 0);
    @(negedge clk_2);
    reset = 1'b0;
    spd_req = 2'd0;

    // Wrap: 256 high-speed sweeps take the counter 255 -> 0.
    spd_req = 2'd2;
    k = 0;
    while (sweep_cnt != 8'd255 && k < 4000) begin
      @(negedge clk_2);
      k++;
    end
    chk("wrap_reach_255", int'(sweep_cnt), 255);
    k = 0;
    while (sweep_cnt == 8'd255 && k < 20) begin
      @(negedge clk_2);
      k++;
    end
    chk("wrap_to_0", int'(sweep_cnt), 0);
    spd_req = 2'd0;
    wait_state(0, 100, "wrap_stop_park");

    // Random phase, checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(0, 7) == 0) spd_req = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) manual_en = ~manual_en;
      if ($urandom_range(0, 7) == 0) manual_spd = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) wash_req = ~wash_req;
      if ($urandom_range(0, 599) == 0) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end
    end

    @(negedge clk_2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
